mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the bus cycles allowed for bus_ack before an access fault is raised.
REQ-002 The block SHALL have the following ports, clock and reset first:
  clk  in  1  system clock, rising edge
  rst  in  1  asynchronous active-high reset
  load_access  in  1  load request from ID_EX
  store_access  in  1  store request from ID_EX
  funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
  load_addr  in  32  load byte address
  store_addr  in  32  store byte address
  store_data  in  32  store data, right-aligned
  flush  in  1  discard current or pending access result
  bus_req  out  1  bus request
  bus_we  out  1  1 = write
  bus_addr  out  32  word address, bits[1:0] = 0
  bus_wdata  out  32  lane-replicated write data
  bus_byte_en  out  4  byte lane enables
  bus_ack  in  1  one-cycle completion strobe
  bus_rdata  in  32  read word, valid with bus_ack
  stall  out  1  freeze upstream pipeline
  load_data  out  32  extended load result
  load_valid  out  1  one-cycle load result strobe
  exception  out  1  one-cycle exception strobe
  exception_cause  out  4  4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
  exception_addr  out  32  faulting byte address
REQ-003 Clock SHALL be clk; reset SHALL be rst, asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-005 IDLE with request and flush=0: latch address, funct3, data and direction; stall=1 combinationally in that cycle.
REQ-006 If store_access and load_access are both 1, the store SHALL win and the load is ignored.
REQ-007 Misalignment: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, SHALL go IDLE->DONE with no bus_req and an exception pending (cause 4 or 6).
REQ-008 Aligned request SHALL go IDLE->ACCESS; bus_req=1 from the next cycle.
REQ-009 ACCESS: bus_req, bus_we, bus_addr, bus_wdata and bus_byte_en SHALL be held stable until bus_ack; stall=1 throughout.
REQ-010 Byte enables: byte access 1<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111; same for loads and stores.
REQ-011 Store data: byte replicated to all 4 lanes; half replicated to both halves; word passed unchanged.
REQ-012 Loads: select the lane from bus_rdata using the latched addr[1:0]; sign-extend for B/H, zero-extend for BU/HU.
REQ-013 Undefined funct3 values SHALL be treated as word access.
REQ-014 bus_ack in ACCESS: capture load_data, drop bus_req in the next cycle, go to DONE.
REQ-015 Timeout counter: cleared on entry to ACCESS and incremented each ACCESS cycle without ack.
REQ-016 On TIMEOUT_CYCLES cycles without ack, the block SHALL drop bus_req, go to DONE and raise cause 5 or 7.
REQ-017 bus_ack in the same cycle as the timeout SHALL count as success.
REQ-018 DONE lasts 1 cycle with stall=0. It asserts load_valid for a successful load, or exception with exception_cause and exception_addr, then returns to IDLE.
REQ-019 Request inputs SHALL be ignored in DONE.
REQ-020 A successful store SHALL produce no strobe in DONE.
REQ-021 flush in IDLE SHALL suppress request acceptance.
REQ-022 flush in ACCESS SHALL set a sticky kill flag. The bus transaction still completes or times out, but the DONE strobes are suppressed.
REQ-023 flush in DONE SHALL suppress the strobes.
REQ-024 bus_ack outside ACCESS SHALL be ignored.
REQ-025 load_data SHALL hold its last value between loads.

Reset
REQ-026 While rst is 1, the block SHALL hold state IDLE and timeout counter 0. It SHALL hold bus_req, bus_we, stall, load_valid and exception at 0, and bus_addr, bus_wdata, bus_byte_en, load_data, exception_cause, exception_addr and the kill flag at 0.
REQ-027 rst asserted mid-ACCESS SHALL drop bus_req immediately (asynchronously).

Verification
REQ-028 LB at 0x1003, bus_rdata=0x80FF_FF7F, ack after 2 cycles -> bus_addr=0x1000, byte_en=1000, load_data=0xFFFF_FF80, load_valid for 1 cycle.
REQ-029 SH at 0x2002, store_data=0x1234_ABCD -> bus_we=1, byte_en=1100, bus_wdata=0xABCD_ABCD; no strobe in DONE.
REQ-030 LW at 0x3001 -> no bus_req; exception=1 with cause 4 and exception_addr=0x3001; stall high for 1 cycle only.
REQ-031 SW with bus_ack never returned, TIMEOUT_CYCLES=16 -> bus_req high 16 cycles, then exception cause 7.
REQ-032 LHU at 0x4000, flush in the 1st ACCESS cycle, ack later with 0x0000_F00D -> transaction completes; load_valid stays 0; back to IDLE.
REQ-033 rst pulse during ACCESS -> all outputs 0 asynchronously; a new LW after release works normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: turns one ID_EX memory request into a single word-bus
// transaction with lane steering, misalignment detection, bus timeout and flush handling.
`timescale 1ns/1ps
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_access,
   input  logic        store_access,
   input  logic [2:0]  funct3,
   input  logic [31:0] load_addr,
   input  logic [31:0] store_addr,
   input  logic [31:0] store_data,
   input  logic        flush,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_byte_en,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        exception,
   output logic [3:0]  exception_cause,
   output logic [31:0] exception_addr
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_addr;
   logic [2:0]       r_funct3;
   logic             r_is_store;
   logic             r_kill;
   logic             r_err;
   logic             r_bus_req;
   logic             r_bus_we;
   logic [31:0]      r_bus_addr;
   logic [31:0]      r_bus_wdata;
   logic [3:0]       r_bus_be;
   logic [31:0]      r_load_data;
   logic [3:0]       r_cause;
   logic [31:0]      r_exc_addr;

   logic        w_accept;
   logic [31:0] w_addr;
   logic        w_is_byte;
   logic        w_is_half;
   logic        w_misal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_lane_b;
   logic [15:0] w_lane_h;
   logic [31:0] w_load_ext;

   // Request decode; the store side wins when both request lines are raised.
   always_comb begin
      w_addr    = store_access ? store_addr : load_addr;
      w_is_byte = (funct3[1:0] == 2'b00);
      w_is_half = (funct3[1:0] == 2'b01);
      w_misal   = w_is_half ? w_addr[0] : (!w_is_byte && (w_addr[1:0] != 2'b00));
      w_accept  = (r_state == S_IDLE) && (store_access || load_access) && !flush;
      if (w_is_byte) begin
         w_be    = 4'b0001 << w_addr[1:0];
         w_wdata = {4{store_data[7:0]}};
      end else if (w_is_half) begin
         w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{store_data[15:0]}};
      end else begin
         w_be    = 4'b1111;
         w_wdata = store_data;
      end
   end

   // Lane extraction uses the latched address, since the request inputs have moved on.
   always_comb begin
      w_lane_b = bus_rdata[{r_addr[1:0], 3'b000} +: 8];
      w_lane_h = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (r_funct3[1:0])
         2'b00:   w_load_ext = r_funct3[2] ? {24'd0, w_lane_b} : {{24{w_lane_b[7]}}, w_lane_b};
         2'b01:   w_load_ext = r_funct3[2] ? {16'd0, w_lane_h} : {{16{w_lane_h[15]}}, w_lane_h};
         default: w_load_ext = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_funct3    <= '0;
         r_is_store  <= 1'b0;
         r_kill      <= 1'b0;
         r_err       <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_be    <= '0;
         r_load_data <= '0;
         r_cause     <= '0;
         r_exc_addr  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_kill <= 1'b0;
               if (w_accept) begin
                  r_addr     <= w_addr;
                  r_funct3   <= funct3;
                  r_is_store <= store_access;
                  if (w_misal) begin
                     r_err      <= 1'b1;
                     r_cause    <= store_access ? 4'd6 : 4'd4;
                     r_exc_addr <= w_addr;
                     r_state    <= S_DONE;
                  end else begin
                     r_err       <= 1'b0;
                     r_cnt       <= '0;
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= store_access;
                     r_bus_addr  <= {w_addr[31:2], 2'b00};
                     r_bus_wdata <= w_wdata;
                     r_bus_be    <= w_be;
                     r_state     <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (flush) r_kill <= 1'b1;
               // An ack on the final allowed cycle still wins over the timeout.
               if (bus_ack) begin
                  r_bus_req <= 1'b0;
                  r_bus_we  <= 1'b0;
                  if (!r_is_store) r_load_data <= w_load_ext;
                  r_state   <= S_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_bus_req  <= 1'b0;
                  r_bus_we   <= 1'b0;
                  r_err      <= 1'b1;
                  r_cause    <= r_is_store ? 4'd7 : 4'd5;
                  r_exc_addr <= r_addr;
                  r_state    <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus_req         = r_bus_req;
   assign bus_we          = r_bus_we;
   assign bus_addr        = r_bus_addr;
   assign bus_wdata       = r_bus_wdata;
   assign bus_byte_en     = r_bus_be;
   assign load_data       = r_load_data;
   assign exception_cause = r_cause;
   assign exception_addr  = r_exc_addr;
   assign stall           = w_accept || (r_state == S_ACCESS);
   // Strobes are gated live by flush so a flush arriving in DONE still cancels them.
   assign load_valid      = (r_state == S_DONE) && !r_is_store && !r_err && !r_kill && !flush;
   assign exception       = (r_state == S_DONE) && r_err && !r_kill && !flush;

endmodule
